lcd_spi_writer: RTL

//  Serialiser directly downstream of the LCD row/window sequencer. Takes one 9-bit LCD word
//  (bit8 = D/C: 0 command, 1 parameter/pixel data; bits7:0 = payload) and shifts it out
//  MSB-first over 4-wire SPI, mode 0 (SCLK idles low, MOSI changes on falling edge, panel

---
 rtl/lcd_spi_writer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lcd_spi_writer.sv
// Serialises one 9-bit LCD word {dc, byte} MSB-first over 4-wire SPI mode 0.
// All outputs are registered; wr_done pulses once per completed word.
module lcd_spi_writer #(
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       en_write,
   input  logic [8:0] wr_data,
   output logic       wr_done,
   output logic       busy,
   output logic       lcd_cs_n,
   output logic       lcd_dc,
   output logic       lcd_sclk,
   output logic       lcd_mosi
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GAP} state_t;

   state_t           state_q, state_nx;
   logic [DIV_W-1:0] div_q, div_nx;
   logic [2:0]       bit_q, bit_nx;
   logic [GAP_W-1:0] gap_q, gap_nx;
   logic [7:0]       shreg_q, shreg_nx;
   logic             cs_n_nx, sclk_nx, mosi_nx, dc_nx, done_nx, busy_nx;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         gap_q    <= '0;
         lcd_cs_n <= 1'b1;
         lcd_sclk <= 1'b0;
         lcd_mosi <= 1'b0;
         lcd_dc   <= 1'b0;
         wr_done  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_nx;
         div_q    <= div_nx;
         bit_q    <= bit_nx;
         gap_q    <= gap_nx;
         lcd_cs_n <= cs_n_nx;
         lcd_sclk <= sclk_nx;
         lcd_mosi <= mosi_nx;
         lcd_dc   <= dc_nx;
         wr_done  <= done_nx;
         busy     <= busy_nx;
      end
   end

   // The shift register carries data only; its contents are meaningless outside a word.
   always_ff @(posedge sys_clk) begin
      shreg_q <= shreg_nx;
   end

   always_comb begin
      state_nx = state_q;
      div_nx   = div_q;
      bit_nx   = bit_q;
      gap_nx   = gap_q;
      shreg_nx = shreg_q;
      cs_n_nx  = lcd_cs_n;
      sclk_nx  = lcd_sclk;
      mosi_nx  = lcd_mosi;
      dc_nx    = lcd_dc;
      done_nx  = 1'b0;
      busy_nx  = busy;
      case (state_q)
         S_IDLE: begin
            cs_n_nx = 1'b1;
            sclk_nx = 1'b0;
            busy_nx = 1'b0;
            if (en_write) begin
               state_nx = S_SETUP;
               shreg_nx = wr_data[7:0];
               dc_nx    = wr_data[8];
               mosi_nx  = wr_data[7];
               cs_n_nx  = 1'b0;
               busy_nx  = 1'b1;
               div_nx   = '0;
               bit_nx   = '0;
            end
         end
         S_SETUP: begin
            if (div_q == DIV_LAST) begin
               state_nx = S_SHIFT;
               div_nx   = '0;
               sclk_nx  = 1'b1;
            end else begin
               div_nx = div_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_nx = '0;
               if (lcd_sclk) begin
                  // Falling edge: present the next bit, except after bit0 where mosi holds.
                  sclk_nx = 1'b0;
                  if (bit_q != 3'd7) begin
                     shreg_nx = {shreg_q[6:0], 1'b0};
                     mosi_nx  = shreg_q[6];
                  end
               end else if (bit_q == 3'd7) begin
                  state_nx = S_DONE;
                  bit_nx   = '0;
                  cs_n_nx  = 1'b1;
                  done_nx  = 1'b1;
               end else begin
                  bit_nx  = bit_q + 1'b1;
                  sclk_nx = 1'b1;
               end
            end else begin
               div_nx = div_q + 1'b1;
            end
         end
         S_DONE: begin
            state_nx = S_GAP;
            gap_nx   = '0;
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_nx = S_IDLE;
               busy_nx  = 1'b0;
            end else begin
               gap_nx = gap_q + 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end
endmodule
